// File: rtl/avg_pkg.sv
// Shared types and default sizing for the two-channel ADC averaging sequencer.
// Default values here are overridden per instance through module parameters.
package avg_pkg;
    localparam int DATA_W_DEF      = 12;
    localparam int LOG2_N_DEF      = 3;
    localparam int OUTS_PER_CH_DEF = 256;
    localparam int ACC_W           = DATA_W_DEF + LOG2_N_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMP_A = 2'd1,
        SAMP_B = 2'd2
    } state_t;
endpackage

// File: rtl/avg_sample_sequencer_if.sv
// ADC-side and result-side handshake bundle between the sequencer and its neighbours.
// master = sequencer, slave = ADC front end plus downstream consumer.
interface avg_sample_sequencer_if #(
    parameter int DATA_W = 12
);
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              adc_chan_sel;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic              out_last;

    modport master (
        input  adc_valid, adc_data, out_ready,
        output adc_chan_sel, out_valid, out1, out2, out_last
    );

    modport slave (
        output adc_valid, adc_data, out_ready,
        input  adc_chan_sel, out_valid, out1, out2, out_last
    );
endinterface

// File: rtl/avg_accum.sv
// Per-channel clear/add accumulator with a combinational divide by 2^LOG2_N of (acc + din).
// Zero latency on avg; AVG_ROUND_EN selects round-to-nearest with saturation, else truncation.
// No backpressure: the caller decides when to add or clear.
module avg_accum
    import avg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] avg
);
    localparam int AW = DATA_W + LOG2_N;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] sum;

    // sum already includes the sample being accepted, so the final strobe feeds the result
    assign sum = acc_q + (add ? AW'(din) : '0);

`ifdef AVG_ROUND_EN
    localparam logic [AW:0] HALF = (AW + 1)'(1) << (LOG2_N - 1);
    logic [AW:0] quo;
    assign quo = ({1'b0, sum} + HALF) >> LOG2_N;
    assign avg = (|quo[AW:DATA_W]) ? '1 : quo[DATA_W-1:0];
`else
    assign avg = DATA_W'(sum >> LOG2_N);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_q <= '0;
        else if (clr)
            acc_q <= '0;
        else
            acc_q <= sum;
    end
endmodule

// File: rtl/avg_sample_sequencer.sv
// Alternates the ADC mux A/B per accepted sample and emits paired 2^LOG2_N-sample averages.
// Result valid 1 cycle after the final B strobe; AVG_ROUND_EN enables rounding in avg_accum.
// Backpressure: an unaccepted result is overwritten by the next one and overrun is flagged.
module avg_sample_sequencer
    import avg_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LOG2_N      = LOG2_N_DEF,
    parameter int OUTS_PER_CH = OUTS_PER_CH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chirp_start,
    avg_sample_sequencer_if.master bus,
    output logic                  busy,
    output logic                  overrun
);
    localparam int CNT_W = (OUTS_PER_CH > 1) ? $clog2(OUTS_PER_CH) : 1;
    localparam logic [LOG2_N-1:0] PAIR_LAST = '1;
    localparam logic [CNT_W-1:0]  OUT_LAST  = CNT_W'(OUTS_PER_CH - 1);

    state_t             state_q, state_d;
    logic [LOG2_N-1:0]  pair_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic               add_a, add_b, final_b, frame_end, acc_clr;
    logic [DATA_W-1:0]  avg_a, avg_b;

    // a restart in the same cycle as a strobe discards the sample
    assign add_a     = (state_q == SAMP_A) && bus.adc_valid && !chirp_start;
    assign add_b     = (state_q == SAMP_B) && bus.adc_valid && !chirp_start;
    assign final_b   = add_b && (pair_cnt_q == PAIR_LAST);
    assign frame_end = final_b && (out_cnt_q == OUT_LAST);
    assign acc_clr   = chirp_start || final_b;
    assign busy      = (state_q != IDLE);

    avg_accum #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_acc_a (
        .clk (clk), .rst (reset), .clr (acc_clr), .add (add_a),
        .din (bus.adc_data), .avg (avg_a)
    );

    avg_accum #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_acc_b (
        .clk (clk), .rst (reset), .clr (acc_clr), .add (add_b),
        .din (bus.adc_data), .avg (avg_b)
    );

    always_comb begin
        state_d = state_q;
        if (chirp_start) begin
            state_d = SAMP_A;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SAMP_A:  if (bus.adc_valid) state_d = SAMP_B;
                SAMP_B:  if (bus.adc_valid) state_d = frame_end ? IDLE : SAMP_A;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            bus.adc_chan_sel <= 1'b0;
            pair_cnt_q       <= '0;
            out_cnt_q        <= '0;
        end else begin
            state_q          <= state_d;
            bus.adc_chan_sel <= (state_d == SAMP_B);
            if (chirp_start) begin
                pair_cnt_q <= '0;
                out_cnt_q  <= '0;
            end else begin
                if (add_b)
                    pair_cnt_q <= pair_cnt_q + 1'b1;
                if (final_b)
                    out_cnt_q <= frame_end ? '0 : out_cnt_q + 1'b1;
            end
        end
    end

    // result register survives a chirp restart; only reset drops a pending result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out1      <= '0;
            bus.out2      <= '0;
            bus.out_last  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (final_b) begin
                bus.out_valid <= 1'b1;
                bus.out1      <= avg_a;
                bus.out2      <= avg_b;
                bus.out_last  <= frame_end;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end

            if (chirp_start)
                overrun <= 1'b0;
            else if (final_b && bus.out_valid && !bus.out_ready)
                overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avg_sample_sequencer.sv
// Directed bench for avg_sample_sequencer with OUTS_PER_CH=4 so frame end is reachable quickly.
// Rounding-dependent expectations follow AVG_ROUND_EN.
module tb_avg_sample_sequencer;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic reset;
    logic chirp_start;
    logic busy;
    logic overrun;
    int   total = 0;
    int   bad   = 0;

    avg_sample_sequencer_if #(.DATA_W(DW)) bus ();

    avg_sample_sequencer #(
        .DATA_W      (DW),
        .LOG2_N      (3),
        .OUTS_PER_CH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chirp_start (chirp_start),
        .bus         (bus),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input int d);
        bus.adc_valid = 1'b1;
        bus.adc_data  = 12'(d);
        tick();
        bus.adc_valid = 1'b0;
    endtask

    task automatic chirp();
        chirp_start = 1'b1;
        tick();
        chirp_start = 1'b0;
    endtask

    task automatic pairs(input int n, input int a, input int b);
        for (int i = 0; i < n; i++) begin
            smp(a);
            smp(b);
        end
    endtask

    initial begin
        reset         = 1'b1;
        chirp_start   = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out1", 32'(bus.out1), 0);
        chk("rst_out2", 32'(bus.out2), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_chan_sel", 32'(bus.adc_chan_sel), 0);
        reset = 1'b0;
        tick();

        // basic averaging, result accepted immediately
        chirp();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_sel_a", 32'(bus.adc_chan_sel), 0);
        smp(100);
        chk("t1_sel_b", 32'(bus.adc_chan_sel), 1);
        smp(200);
        chk("t1_sel_a2", 32'(bus.adc_chan_sel), 0);
        pairs(7, 100, 200);
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_out1", 32'(bus.out1), 100);
        chk("t1_out2", 32'(bus.out2), 200);
        chk("t1_last", 32'(bus.out_last), 0);
        tick();
        chk("t1_valid_drop", 32'(bus.out_valid), 0);

        // A = 0..7 (sum 28), B = 4095 (sum 32760)
        chirp();
        for (int i = 0; i < 8; i++) begin
            smp(i);
            smp(4095);
        end
`ifdef AVG_ROUND_EN
        chk("t2_out1", 32'(bus.out1), 4);
`else
        chk("t2_out1", 32'(bus.out1), 3);
`endif
        chk("t2_out2", 32'(bus.out2), 4095);
        tick();

        // two results with no acceptance -> overwrite and overrun
        chirp();
        bus.out_ready = 1'b0;
        pairs(8, 10, 20);
        chk("t3_valid1", 32'(bus.out_valid), 1);
        chk("t3_out1_first", 32'(bus.out1), 10);
        chk("t3_out2_first", 32'(bus.out2), 20);
        chk("t3_ovr_clear", 32'(overrun), 0);
        pairs(8, 30, 50);
        chk("t3_out1_second", 32'(bus.out1), 30);
        chk("t3_out2_second", 32'(bus.out2), 50);
        chk("t3_valid2", 32'(bus.out_valid), 1);
        chk("t3_ovr_set", 32'(overrun), 1);
        chirp();
        chk("t3_ovr_chirp", 32'(overrun), 0);
        chk("t3_keep_valid", 32'(bus.out_valid), 1);
        chk("t3_keep_out1", 32'(bus.out1), 30);
        bus.out_ready = 1'b1;
        tick();
        chk("t3_accept", 32'(bus.out_valid), 0);

        // frame end after 4 results
        chirp();
        for (int k = 0; k < 3; k++) begin
            pairs(8, 16 * (k + 1), 1000 + k);
            chk("t4_out1", 32'(bus.out1), 32'(16 * (k + 1)));
            chk("t4_out2", 32'(bus.out2), 32'(1000 + k));
            chk("t4_last0", 32'(bus.out_last), 0);
            chk("t4_busy", 32'(busy), 1);
        end
        bus.out_ready = 1'b0;
        pairs(8, 77, 88);
        chk("t4_valid_end", 32'(bus.out_valid), 1);
        chk("t4_last1", 32'(bus.out_last), 1);
        chk("t4_idle", 32'(busy), 0);
        chk("t4_out1_end", 32'(bus.out1), 77);
        tick();
        chk("t4_valid_hold", 32'(bus.out_valid), 1);
        chk("t4_last_hold", 32'(bus.out_last), 1);
        smp(999);
        smp(999);
        chk("t4_idle_ign_busy", 32'(busy), 0);
        chk("t4_idle_ign_sel", 32'(bus.adc_chan_sel), 0);
        chk("t4_idle_ign_out1", 32'(bus.out1), 77);
        bus.out_ready = 1'b1;
        tick();
        chk("t4_accept_valid", 32'(bus.out_valid), 0);
        chk("t4_accept_last", 32'(bus.out_last), 0);

        // restart after 5 samples, restart coincident with a strobe
        chirp();
        for (int i = 0; i < 5; i++) smp(500);
        chk("t5_sel_before", 32'(bus.adc_chan_sel), 1);
        chirp_start   = 1'b1;
        bus.adc_valid = 1'b1;
        bus.adc_data  = 12'd4000;
        tick();
        chirp_start   = 1'b0;
        bus.adc_valid = 1'b0;
        chk("t5_sel_after", 32'(bus.adc_chan_sel), 0);
        chk("t5_busy", 32'(busy), 1);
        pairs(8, 40, 80);
        chk("t5_valid", 32'(bus.out_valid), 1);
        chk("t5_out1", 32'(bus.out1), 40);
        chk("t5_out2", 32'(bus.out2), 80);
        tick();

        // asynchronous reset with a pending result
        chirp();
        bus.out_ready = 1'b0;
        pairs(8, 7, 9);
        chk("t6_valid_pre", 32'(bus.out_valid), 1);
        smp(1);
        smp(2);
        smp(3);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", 32'(bus.out_valid), 0);
        chk("t6_out1", 32'(bus.out1), 0);
        chk("t6_out2", 32'(bus.out2), 0);
        chk("t6_last", 32'(bus.out_last), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_sel", 32'(bus.adc_chan_sel), 0);
        chk("t6_ovr", 32'(overrun), 0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
